// File: rtl/piso_serializer.sv
// piso_serializer
// ---------------------------------------------------------------------------
// Parallel-in, serial-out stage. A WIDTH-bit word is accepted over a
// valid/ready handshake and driven onto dout one bit per clock, either MSB
// first (LSB_FIRST=0) or LSB first (LSB_FIRST=1). Words may follow each other
// with no idle cycle: load_ready rises while the final bit of the current word
// is on the line, so the next word's first bit directly follows it.
//
// Optional feature (compile-time macro PARITY_TX_EN):
//   defined   - every word is followed by one extra cycle carrying the
//               even-parity bit of the captured data (WIDTH+1 cycles/word).
//   undefined - no parity cycle; a word occupies exactly WIDTH cycles.
//
// Ports:
//   clk        - system clock, all logic on the rising edge
//   rst        - synchronous active-high reset; discards any word in flight
//   din        - parallel word to transmit
//   load_valid - din is valid this cycle
//   load_ready - block accepts a word this cycle (combinational, 0 during rst)
//   dout       - registered serial data out
//   dout_valid - registered, dout carries a live bit
//   busy       - a word (data or parity bit) is on the line (= dout_valid)
//   done       - registered, high together with the final bit of a word
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  // Counter value while the final data bit is on dout, and the one before.
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

`ifdef PARITY_TX_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10
  } state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [WIDTH-1:0] data);
    even_parity = ^data;
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;     // bits still to be sent, next bit at the output end
  logic [CW-1:0]    cnt_q, cnt_d;         // index of the data bit currently on dout
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             done_q, done_d;
`ifdef PARITY_TX_EN
  logic             par_q, par_d;         // parity of the word in flight
`endif

  logic             last_bit;             // final bit of the current word is on dout
  logic             accept;
  logic             first_bit;            // first bit of din in transmit order
  logic [WIDTH-1:0] load_shreg;           // din with its first bit already consumed
  logic             next_bit;             // next bit of the word in flight
  logic [WIDTH-1:0] shift_shreg;          // shreg after consuming next_bit

  // Identify the cycle holding the last bit of a word on the line.
`ifdef PARITY_TX_EN
  assign last_bit = (state_q == ST_PARITY);
`else
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST);
`endif

  assign load_ready = ~rst & ((state_q == ST_IDLE) | last_bit);
  assign accept     = load_valid & load_ready;

  // Bit-order dependent selection of the bits leaving the shift register.
  always_comb begin
    first_bit   = 1'b0;
    load_shreg  = '0;
    next_bit    = 1'b0;
    shift_shreg = '0;
    if (LSB_FIRST) begin
      first_bit   = din[0];
      load_shreg  = {1'b0, din[WIDTH-1:1]};
      next_bit    = shreg_q[0];
      shift_shreg = {1'b0, shreg_q[WIDTH-1:1]};
    end else begin
      first_bit   = din[WIDTH-1];
      load_shreg  = {din[WIDTH-2:0], 1'b0};
      next_bit    = shreg_q[WIDTH-1];
      shift_shreg = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and next-output logic for the serializer FSM.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    done_d       = 1'b0;
`ifdef PARITY_TX_EN
    par_d        = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_SHIFT;
          shreg_d      = load_shreg;
          cnt_d        = '0;
          dout_d       = first_bit;
          dout_valid_d = 1'b1;
`ifdef PARITY_TX_EN
          par_d        = even_parity(din);
`endif
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == LAST) begin
`ifdef PARITY_TX_EN
          // Data exhausted: the parity bit ends the word.
          state_d      = ST_PARITY;
          dout_d       = par_q;
          dout_valid_d = 1'b1;
          done_d       = 1'b1;
`else
          // Final data bit is on the line; chain the next word if offered.
          if (accept) begin
            state_d      = ST_SHIFT;
            shreg_d      = load_shreg;
            cnt_d        = '0;
            dout_d       = first_bit;
            dout_valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
`endif
        end else begin
          state_d      = ST_SHIFT;
          shreg_d      = shift_shreg;
          cnt_d        = cnt_q + 1'b1;
          dout_d       = next_bit;
          dout_valid_d = 1'b1;
`ifdef PARITY_TX_EN
          done_d       = 1'b0;
`else
          done_d       = (cnt_q == PRE_LAST);
`endif
        end
      end

`ifdef PARITY_TX_EN
      ST_PARITY: begin
        // Parity bit is on the line; chain the next word if offered.
        if (accept) begin
          state_d      = ST_SHIFT;
          shreg_d      = load_shreg;
          cnt_d        = '0;
          dout_d       = first_bit;
          dout_valid_d = 1'b1;
          par_d        = even_parity(din);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef PARITY_TX_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
`ifdef PARITY_TX_EN
      par_q        <= par_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = dout_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
// Directed bench for piso_serializer: one MSB-first and one LSB-first
// instance (WIDTH=8) on a shared clock and reset. Outputs are sampled 1 ns
// after each rising edge; inputs change at the same point and take effect at
// the following edge. Expected bit streams are written out by hand.
module tb_piso_serializer;

`ifdef PARITY_TX_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 8 + P;   // cycles per word on the line

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] m_din;
  logic       m_valid, m_ready, m_dout, m_dvalid, m_busy, m_done;
  logic [7:0] l_din;
  logic       l_valid, l_ready, l_dout, l_dvalid, l_busy, l_done;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .din(m_din), .load_valid(m_valid),
    .load_ready(m_ready), .dout(m_dout), .dout_valid(m_dvalid),
    .busy(m_busy), .done(m_done)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .din(l_din), .load_valid(l_valid),
    .load_ready(l_ready), .dout(l_dout), .dout_valid(l_dvalid),
    .busy(l_busy), .done(l_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check the MSB-first instance for one on-line bit.
  task automatic chk_m_bit(input string tag, input int i, input logic exp_bit,
                           input logic exp_last);
    chk($sformatf("%s dout[%0d]", tag, i), m_dout, exp_bit);
    chk($sformatf("%s dout_valid[%0d]", tag, i), m_dvalid, 1'b1);
    chk($sformatf("%s busy[%0d]", tag, i), m_busy, 1'b1);
    chk($sformatf("%s done[%0d]", tag, i), m_done, exp_last);
    chk($sformatf("%s load_ready[%0d]", tag, i), m_ready, exp_last);
  endtask

  task automatic chk_m_idle(input string tag);
    chk({tag, " dout"}, m_dout, 1'b0);
    chk({tag, " dout_valid"}, m_dvalid, 1'b0);
    chk({tag, " busy"}, m_busy, 1'b0);
    chk({tag, " done"}, m_done, 1'b0);
    chk({tag, " load_ready"}, m_ready, 1'b1);
  endtask

  // Send one or two words on the MSB-first instance and check the stream.
  // p0/p1 are the hand-computed even-parity bits (used only with parity).
  task automatic send_m(input string tag, input logic [7:0] w0, input logic p0,
                        input logic [7:0] w1, input logic p1, input int nw);
    logic [7:0] w;
    logic       p;
    int         pos;
    m_din   = w0;
    m_valid = 1'b1;
    tick();
    if (nw == 2) begin
      m_din = w1;
    end else begin
      m_din   = 8'h5A;   // changing din after accept must not disturb the word
      m_valid = 1'b0;
    end
    for (int i = 0; i < nw * NB; i++) begin
      w   = (i < NB) ? w0 : w1;
      p   = (i < NB) ? p0 : p1;
      pos = i % NB;
      chk_m_bit(tag, i, (pos < 8) ? w[7 - pos] : p, pos == NB - 1);
      if (i == NB) begin
        m_valid = 1'b0;
      end
      tick();
    end
    chk_m_idle({tag, " end"});
  endtask

  initial begin
    rst     = 1'b1;
    m_din   = 8'h00;
    m_valid = 1'b0;
    l_din   = 8'h00;
    l_valid = 1'b0;

    // Reset state and idle behaviour.
    tick();
    tick();
    chk("rst dout", m_dout, 1'b0);
    chk("rst dout_valid", m_dvalid, 1'b0);
    chk("rst busy", m_busy, 1'b0);
    chk("rst done", m_done, 1'b0);
    chk("rst load_ready forced low", m_ready, 1'b0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk_m_idle($sformatf("idle%0d", i));
      chk($sformatf("idle%0d lsb load_ready", i), l_ready, 1'b1);
      tick();
    end

    // Single word, MSB first: A5 -> 10100101 (parity 0).
    send_m("a5", 8'hA5, 1'b0, 8'h00, 1'b0, 1);

    // Back-to-back: A5 then 3C (parity 0 and 0).
    send_m("b2b", 8'hA5, 1'b0, 8'h3C, 1'b0, 2);

    // Parity-sensitive words: 07 -> 00000111 (parity 1), 03 (parity 0).
    send_m("w07", 8'h07, 1'b1, 8'h00, 1'b0, 1);
    send_m("w03", 8'h03, 1'b0, 8'h00, 1'b0, 1);

    // Reset mid-word: FF, rst during the 4th bit.
    m_din   = 8'hFF;
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_m_bit("ffrst", i, 1'b1, 1'b0);
      if (i < 3) begin
        tick();
      end
    end
    rst = 1'b1;
    #1;
    chk("ffrst load_ready during rst", m_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk_m_idle("ffrst after");
    for (int i = 0; i < NB; i++) begin
      tick();
      chk($sformatf("ffrst no done %0d", i), m_done, 1'b0);
      chk($sformatf("ffrst no valid %0d", i), m_dvalid, 1'b0);
    end

    // LSB first: 01 -> 1 then seven 0s (parity 1); AA pulse while busy ignored.
    l_din   = 8'h01;
    l_valid = 1'b1;
    tick();
    l_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("lsb dout[%0d]", i), l_dout, (i == 0) || (i == 8));
      chk($sformatf("lsb dout_valid[%0d]", i), l_dvalid, 1'b1);
      chk($sformatf("lsb done[%0d]", i), l_done, i == NB - 1);
      chk($sformatf("lsb load_ready[%0d]", i), l_ready, i == NB - 1);
      if (i == 2) begin
        l_din   = 8'hAA;
        l_valid = 1'b1;
      end else begin
        l_valid = 1'b0;
      end
      tick();
    end
    chk("lsb end dout", l_dout, 1'b0);
    chk("lsb end dout_valid", l_dvalid, 1'b0);
    chk("lsb end busy", l_busy, 1'b0);
    chk("lsb end load_ready", l_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out stage that sits directly upstream of the 8-bit serial-in serial-out shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per clock onto the serial line feeding the shifter's d input.
- Supports back-to-back words with no idle gap and an optional trailing even-parity bit.

Parameters:
WIDTH, 8, data word width in bits (>= 2)
LSB_FIRST, 0, 0 = MSB transmitted first; 1 = LSB transmitted first

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
din  input  WIDTH  parallel word to transmit
load_valid  input  1  din is valid this cycle
load_ready  output  1  block accepts a word this cycle (combinational from state/counter)
dout  output  1  serial data out, registered; drives shifter d
dout_valid  output  1  dout carries a live bit, registered
busy  output  1  high while a word (data or parity bit) is on the line
done  output  1  one-cycle pulse coincident with the final bit of a word

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on any rising edge with rst=1 -> state IDLE, shift register 0, bit counter 0, dout=0, dout_valid=0, busy=0, done=0. rst overrides load_valid and any in-flight transfer; the word in flight is discarded, not completed.
- States: IDLE, SHIFT, PARITY (PARITY exists only with PARITY_TX_EN).
- load_ready = (state==IDLE) OR (final bit of the current word is on dout). load_ready is forced 0 while rst=1.
- Accept: a word is accepted on the edge where load_valid && load_ready. At that edge din is captured, the first bit (din[WIDTH-1], or din[0] if LSB_FIRST) is registered onto dout, dout_valid<=1, counter<=0, state<=SHIFT.
- Latency: first bit is visible the cycle after the accept edge; bit k is visible k cycles after that (k = 0..WIDTH-1).
- SHIFT: each edge advances one bit and increments the counter. At counter==WIDTH-1 the final data bit is on dout:
  - Without PARITY_TX_EN: done=1 this cycle. Next edge: new accept -> first bit of the new word, no gap; otherwise -> IDLE, dout=0, dout_valid=0.
  - With PARITY_TX_EN: next edge -> PARITY.
- busy = dout_valid.
- load_valid with load_ready=0 is ignored. din is not sampled and no error is raised. The source must hold load_valid.
- din changes after accept have no effect on the word in flight.
- WIDTH=1 is unsupported.

Optional Feature:
Macro PARITY_TX_EN.
- Defined:
  - After the WIDTH data bits, one extra cycle in state PARITY drives the even-parity bit (XOR of all captured data bits) with dout_valid=1.
  - In that cycle done=1 and load_ready may be high, so the next word starts with no gap.
  - A word therefore occupies WIDTH+1 cycles.
- Not defined:
  - The PARITY state and parity logic are absent.
  - A word occupies exactly WIDTH cycles and done coincides with the last data bit.

Test Plan:
- Reset, then hold rst=0 idle 5 cycles -> dout=0, dout_valid=0, busy=0, load_ready=1 throughout.
- WIDTH=8, LSB_FIRST=0, accept 8'hA5 -> dout over next 8 cycles = 1,0,1,0,0,1,0,1; dout_valid high exactly 8 cycles; done high only on the 8th; then IDLE.
- Back-to-back: accept 8'hA5, hold load_valid=1 with din=8'h3C -> 8'h3C accepted on the last-bit cycle of A5. Expect 16 contiguous dout_valid cycles, dout = 10100101 00111100, and two done pulses 8 cycles apart.
- Reset mid-word: accept 8'hFF, assert rst for 1 cycle on the 4th bit -> next cycle dout=0, dout_valid=0, load_ready=1, and no done pulse for that word.
- LSB_FIRST=1, accept 8'h01 -> dout = 1 then seven 0s. A load_valid pulse with din=8'hAA while busy and not on the last bit is not accepted, and the line shows no corruption.
- PARITY_TX_EN defined, accept 8'h07 -> 8 data bits 00000111 then 9th bit 1; dout_valid 9 cycles, done on the 9th. Accept 8'h03 -> 9th bit 0.
